// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: compares programmed hh:mm slots against the running
// clock on each whole-minute tick and sequences ring / snooze / stop / timeout.
module alarm_scheduler #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_minute,
  input  logic [5:0] cur_second,
  input  logic       cfg_we,
  input  logic [1:0] cfg_slot,
  input  logic [4:0] cfg_hour,
  input  logic [5:0] cfg_minute,
  input  logic       cfg_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       alarm,
  output logic [1:0] ring_slot,
  output logic [1:0] state,
  output logic [2:0] snooze_cnt,
  output logic       cfg_err
);

  localparam int unsigned SLOTS  = 4;
  localparam int unsigned TMR_W  = 10;
  localparam logic [2:0]  NUM_A  = 3'(NUM_ALARMS);
  localparam logic [2:0]  MAX_S  = 3'(MAX_SNOOZE);
  localparam logic [TMR_W-1:0] RING_T  = TMR_W'(RING_SEC);
  localparam logic [TMR_W-1:0] SNOOZ_T = TMR_W'(SNOOZE_SEC);

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RING   = 2'b01;
  localparam logic [1:0] ST_SNOOZE = 2'b10;

  logic [4:0]       r_hour [SLOTS];
  logic [5:0]       r_min  [SLOTS];
  logic [SLOTS-1:0] r_en;
  logic             r_cfg_err;

  logic [1:0]       r_state,   w_state_nxt;
  logic             r_alarm,   w_alarm_nxt;
  logic [1:0]       r_slot,    w_slot_nxt;
  logic [2:0]       r_cnt,     w_cnt_nxt;
  logic [TMR_W-1:0] r_timer,   w_timer_nxt;

  logic             w_cfg_ok;
  logic             w_minute_tick;
  logic [SLOTS-1:0] w_match;
  logic             w_any;
  logic [1:0]       w_win;

  assign w_cfg_ok = ({1'b0, cfg_slot} < NUM_A) && (cfg_hour <= 5'd23) && (cfg_minute <= 6'd59);
  assign w_minute_tick = sec_tick && (cur_second == 6'd0);

  // Slot storage; out-of-range writes are dropped and flagged one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) begin
        r_hour[i] <= '0;
        r_min[i]  <= '0;
      end
      r_en      <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (cfg_we && w_cfg_ok) begin
        r_hour[cfg_slot] <= cfg_hour;
        r_min[cfg_slot]  <= cfg_minute;
        r_en[cfg_slot]   <= cfg_en;
      end
    end
  end

  // Match against registered slot contents, so a same-cycle write is not seen
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      w_match[i] = w_minute_tick && r_en[i] &&
                   (r_hour[i] == cur_hour) && (r_min[i] == cur_minute);
    end
  end

  // Lowest index wins
  always_comb begin
    w_win = 2'd0;
    w_any = 1'b0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_win = 2'(i);
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_alarm <= 1'b0;
      r_slot  <= 2'd0;
      r_cnt   <= 3'd0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_alarm <= w_alarm_nxt;
      r_slot  <= w_slot_nxt;
      r_cnt   <= w_cnt_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_alarm_nxt = r_alarm;
    w_slot_nxt  = r_slot;
    w_cnt_nxt   = r_cnt;
    w_timer_nxt = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_RING;
          w_alarm_nxt = 1'b1;
          w_slot_nxt  = w_win;
          w_cnt_nxt   = 3'd0;
          w_timer_nxt = RING_T;
        end
      end
      ST_RING: begin
        if (stop || (snooze && (r_cnt >= MAX_S))) begin
          w_state_nxt = ST_IDLE;
          w_alarm_nxt = 1'b0;
          w_timer_nxt = '0;
        end else if (snooze) begin
          w_state_nxt = ST_SNOOZE;
          w_alarm_nxt = 1'b0;
          w_cnt_nxt   = r_cnt + 3'd1;
          w_timer_nxt = SNOOZ_T;
        end else if (sec_tick) begin
          if (r_timer <= TMR_W'(1)) begin
            w_state_nxt = ST_IDLE;
            w_alarm_nxt = 1'b0;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer - TMR_W'(1);
          end
        end
      end
      ST_SNOOZE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_alarm_nxt = 1'b0;
          w_timer_nxt = '0;
        end else if (w_any) begin
          // A fresh alarm preempts the snoozed one and starts a new event
          w_state_nxt = ST_RING;
          w_alarm_nxt = 1'b1;
          w_slot_nxt  = w_win;
          w_cnt_nxt   = 3'd0;
          w_timer_nxt = RING_T;
        end else if (sec_tick) begin
          if (r_timer <= TMR_W'(1)) begin
            w_state_nxt = ST_RING;
            w_alarm_nxt = 1'b1;
            w_timer_nxt = RING_T;
          end else begin
            w_timer_nxt = r_timer - TMR_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_alarm_nxt = 1'b0;
        w_timer_nxt = '0;
      end
    endcase
  end

  assign alarm      = r_alarm;
  assign ring_slot  = r_slot;
  assign state      = r_state;
  assign snooze_cnt = r_cnt;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: expected output vectors are queued as
// stimulus is driven and compared after the clock edge that produces them.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic [4:0] cur_hour;
  logic [5:0] cur_minute;
  logic [5:0] cur_second;
  logic       cfg_we;
  logic [1:0] cfg_slot;
  logic [4:0] cfg_hour;
  logic [5:0] cfg_minute;
  logic       cfg_en;
  logic       stop;
  logic       snooze;
  logic       alarm;
  logic [1:0] ring_slot;
  logic [1:0] state;
  logic [2:0] snooze_cnt;
  logic       cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  string      sb_tag[$];
  logic [8:0] sb_exp[$];

  always #5 clk = ~clk;

  alarm_scheduler dut (
    .clk(clk), .reset(reset), .sec_tick(sec_tick),
    .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_hour(cfg_hour),
    .cfg_minute(cfg_minute), .cfg_en(cfg_en), .stop(stop), .snooze(snooze),
    .alarm(alarm), .ring_slot(ring_slot), .state(state),
    .snooze_cnt(snooze_cnt), .cfg_err(cfg_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Vector layout: {alarm, ring_slot, state, snooze_cnt, cfg_err}
  task automatic push_exp(input string tag, input logic al, input logic [1:0] sl,
                          input logic [1:0] st, input logic [2:0] cnt, input logic err);
    sb_tag.push_back(tag);
    sb_exp.push_back({al, sl, st, cnt, err});
  endtask

  task automatic drain();
    while (sb_exp.size() > 0) begin
      check(sb_tag.pop_front(), 32'({alarm, ring_slot, state, snooze_cnt, cfg_err}),
            32'(sb_exp.pop_front()));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int h, input int m, input int s);
    cur_hour   = 5'(h);
    cur_minute = 6'(m);
    cur_second = 6'(s);
    sec_tick   = 1'b1;
    cyc();
    sec_tick   = 1'b0;
  endtask

  task automatic set_cfg(input int sl, input int h, input int m, input logic en);
    cfg_we     = 1'b1;
    cfg_slot   = 2'(sl);
    cfg_hour   = 5'(h);
    cfg_minute = 6'(m);
    cfg_en     = en;
  endtask

  task automatic wr_ok(input int sl, input int h, input int m, input logic en);
    set_cfg(sl, h, m, en);
    push_exp("wr_noerr", alarm, ring_slot, state, snooze_cnt, 1'b0);
    cyc();
    cfg_we = 1'b0;
    drain();
  endtask

  initial begin
    int ring_ticks;
    int n;
    reset = 1'b1; sec_tick = 1'b0; cur_hour = '0; cur_minute = '0; cur_second = '0;
    cfg_we = 1'b0; cfg_slot = '0; cfg_hour = '0; cfg_minute = '0; cfg_en = 1'b0;
    stop = 1'b0; snooze = 1'b0;
    cyc(); cyc();
    push_exp("reset_vals", 0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    drain();
    push_exp("reset_slots_disabled", 0, 0, 0, 0, 0);
    tick(0, 0, 0);
    drain();

    // Basic match at 07:30
    wr_ok(1, 7, 30, 1'b1);
    push_exp("pre_0730", 0, 0, 0, 0, 0);
    tick(7, 29, 59);
    drain();
    push_exp("ring_0730", 1, 1, 1, 0, 0);
    tick(7, 30, 0);
    drain();
    stop = 1'b1;
    push_exp("stop_0730", 0, 1, 0, 0, 0);
    cyc();
    stop = 1'b0;
    drain();

    // Simultaneous match: lowest slot wins, loser discarded
    wr_ok(0, 12, 0, 1'b1);
    wr_ok(2, 12, 0, 1'b1);
    push_exp("tie_lowest", 1, 0, 1, 0, 0);
    tick(12, 0, 0);
    drain();
    stop = 1'b1;
    push_exp("tie_stop", 0, 0, 0, 0, 0);
    cyc();
    stop = 1'b0;
    drain();
    for (int s = 1; s <= 3; s++) begin
      push_exp("tie_no_slot2", 0, 0, 0, 0, 0);
      tick(12, 0, s);
      drain();
    end

    // Snooze three times, fourth snooze stops
    wr_ok(3, 13, 0, 1'b1);
    push_exp("ring_1300", 1, 3, 1, 0, 0);
    tick(13, 0, 0);
    drain();
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      push_exp("snooze_enter", 0, 3, 2, 3'(k), 0);
      cyc();
      snooze = 1'b0;
      drain();
      for (int t = 1; t <= 300; t++) begin
        if (t == 299) push_exp("snooze_hold_299", 0, 3, 2, 3'(k), 0);
        if (t == 300) push_exp("snooze_rering_300", 1, 3, 1, 3'(k), 0);
        tick(13, 0, 30);
        drain();
      end
    end
    snooze = 1'b1;
    push_exp("snooze_max_stop", 0, 3, 0, 3, 0);
    cyc();
    snooze = 1'b0;
    drain();

    // Auto-timeout after RING_SEC ticks
    push_exp("ring_timeout_start", 1, 3, 1, 0, 0);
    tick(13, 0, 0);
    drain();
    ring_ticks = 0;
    n = 0;
    while (state != 2'b00 && n < 100) begin
      if (alarm) ring_ticks++;
      tick(13, 0, 30);
      n++;
    end
    check("ring_tick_count", 32'(ring_ticks), 32'd60);
    check("timeout_state", 32'(state), 32'd0);
    check("timeout_alarm", 32'(alarm), 32'd0);

    // Rejected writes: hour 24, minute 60
    set_cfg(0, 24, 0, 1'b1);
    push_exp("err_hour24", 0, 3, 0, 0, 1);
    cyc();
    cfg_we = 1'b0;
    drain();
    push_exp("err_hour24_clear", 0, 3, 0, 0, 0);
    cyc();
    drain();
    set_cfg(2, 0, 60, 1'b1);
    push_exp("err_min60", 0, 3, 0, 0, 1);
    cyc();
    cfg_we = 1'b0;
    drain();
    push_exp("err_min60_clear", 0, 3, 0, 0, 0);
    cyc();
    drain();
    push_exp("no_ring_midnight", 0, 3, 0, 0, 0);
    tick(0, 0, 0);
    drain();
    push_exp("slot0_unchanged", 1, 0, 1, 0, 0);
    tick(12, 0, 0);
    drain();

    // Write to the ringing slot leaves the event alone
    set_cfg(0, 5, 0, 1'b1);
    push_exp("wr_while_ring", 1, 0, 1, 0, 0);
    cyc();
    cfg_we = 1'b0;
    drain();
    stop = 1'b1;
    push_exp("stop_slot0", 0, 0, 0, 0, 0);
    cyc();
    stop = 1'b0;
    drain();

    // Midnight alarm, then stop and snooze together
    wr_ok(2, 0, 0, 1'b1);
    push_exp("pre_midnight", 0, 0, 0, 0, 0);
    tick(23, 59, 59);
    drain();
    push_exp("ring_midnight", 1, 2, 1, 0, 0);
    tick(0, 0, 0);
    drain();
    stop = 1'b1;
    snooze = 1'b1;
    push_exp("stop_beats_snooze", 0, 2, 0, 0, 0);
    cyc();
    stop = 1'b0;
    snooze = 1'b0;
    drain();

    // Preemption from snooze, then reset during snooze
    push_exp("ring_again", 1, 2, 1, 0, 0);
    tick(0, 0, 0);
    drain();
    snooze = 1'b1;
    push_exp("snooze_slot2", 0, 2, 2, 1, 0);
    cyc();
    snooze = 1'b0;
    drain();
    push_exp("preempt_slot0", 1, 0, 1, 0, 0);
    tick(5, 0, 0);
    drain();
    snooze = 1'b1;
    push_exp("snooze_slot0", 0, 0, 2, 1, 0);
    cyc();
    snooze = 1'b0;
    drain();
    reset = 1'b1;
    push_exp("reset_in_snooze", 0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    drain();
    push_exp("post_reset_cleared", 0, 0, 0, 0, 0);
    tick(5, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
- Multi-slot alarm controller for the digital clock.
- Holds NUM_ALARMS programmable alarm times and compares them against the running clock time on each one-second tick.
- Arbitrates simultaneous matches, and sequences ringing, snooze, stop and auto-timeout.
- Sits beside the timekeeping counter, consumes its binary hour/minute/second plus a 1-cycle second strobe, and drives the alarm output.

Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..4).
- SNOOZE_SEC, 300, seconds spent in snooze before re-ringing (1..1023).
- RING_SEC, 60, seconds of ringing before auto-stop (1..1023).
- MAX_SNOOZE, 3, snoozes allowed per alarm event; a further snooze acts as stop (1..7).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sec_tick  in  1  one-cycle pulse; cur_* hold the new time on this cycle
- cur_hour  in  5  current hour, binary 0..23
- cur_minute  in  6  current minute, binary 0..59
- cur_second  in  6  current second, binary 0..59
- cfg_we  in  1  write strobe for one alarm slot
- cfg_slot  in  2  slot index to write
- cfg_hour  in  5  alarm hour, binary
- cfg_minute  in  6  alarm minute, binary
- cfg_en  in  1  slot enable bit to write
- stop  in  1  level, user stop request
- snooze  in  1  level, user snooze request
- alarm  out  1  ringing indicator
- ring_slot  out  2  slot that caused the current or last event
- state  out  2  00 IDLE, 01 RINGING, 10 SNOOZE
- snooze_cnt  out  3  snoozes used in the current event
- cfg_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clk. Reset is the only reset path.
- Reset values:
  - All slots disabled, times 0.
  - state = IDLE, alarm = 0, ring_slot = 0, snooze_cnt = 0, cfg_err = 0.
  - Internal timers = 0.
- Reset mid-ring or mid-snooze returns to IDLE on the next edge.
- Config writes:
  - With cfg_we = 1, the slot is updated at the edge when cfg_slot < NUM_ALARMS, cfg_hour <= 23 and cfg_minute <= 59.
  - Otherwise the write is dropped and cfg_err pulses for 1 cycle, on the cycle after the write.
  - A write to the ringing slot does not disturb the current event.
- Match:
  - Evaluated only on cycles with sec_tick = 1 and cur_second = 0.
  - Slot i matches when it is enabled and its hour/minute equal cur_hour/cur_minute.
  - Match uses slot contents before any same-cycle write.
  - Multiple matches: the lowest index wins; the others are discarded.
- IDLE:
  - On a match -> RINGING, registered one cycle after the tick.
  - Actions on entry: alarm = 1, ring_slot = winner, snooze_cnt = 0, ring timer = RING_SEC.
  - stop and snooze are ignored.
- RINGING:
  - Priority order: stop > snooze > timeout.
  - stop -> IDLE, alarm = 0.
  - snooze, with snooze_cnt < MAX_SNOOZE -> SNOOZE: snooze_cnt += 1, snooze timer = SNOOZE_SEC, alarm = 0.
  - snooze, with snooze_cnt = MAX_SNOOZE -> IDLE, same as stop.
  - Timeout: the timer decrements on each sec_tick. When a tick finds the timer at 1 -> IDLE, alarm = 0. Ringing therefore lasts RING_SEC ticks.
  - New matches are ignored.
- SNOOZE:
  - The timer decrements on each sec_tick. When a tick finds it at 1 -> RINGING, ring timer reloaded, alarm = 1.
  - stop -> IDLE.
  - A new match from any slot preempts -> RINGING with the new ring_slot, snooze_cnt = 0.
- stop and snooze are level inputs evaluated every clk cycle, not only on ticks.
- Holding snooze across the SNOOZE -> RINGING re-entry snoozes again on the next cycle. Debounce and edge-detection are the requester's job.
- An alarm set to 00:00 fires at midnight rollover like any other time.
- Timer widths are 10 bits, unsigned, with no wrap. Timers never decrement below 1 while active.

Test Plan:
- Reset, then write slot1 = 07:30 en; drive ticks through 07:29:59 -> 07:30:00. Expected: alarm = 1 one cycle after the 07:30:00 tick, ring_slot = 1, state = 01.
- Slots 0 and 2 both = 12:00 en. Expected: at the 12:00:00 tick ring_slot = 0; stop -> alarm = 0, state = 00; slot2 does not ring afterwards.
- Ringing, then snooze. Expected: state = 10, snooze_cnt = 1, alarm = 0; after 300 ticks alarm = 1; repeat snooze three times, and the 4th snooze returns IDLE with snooze_cnt = 3.
- Ringing with no input, RING_SEC = 60. Expected: alarm stays high for exactly 60 ticks, then state = 00.
- cfg_we with hour = 24, and separately with minute = 60. Expected: cfg_err pulses one cycle each; slot contents unchanged; no alarm at 00:00.
- Stop and snooze asserted together while ringing -> IDLE. Separately, reset asserted during SNOOZE -> all outputs at reset values on the next edge.
